// File: rtl/global_avg_pool.sv
// Global average pooling for one convolution channel: sums LAYER_HEIGHT signed
// fixed-point samples, multiplies by a rounded reciprocal and emits a saturated average.
module global_avg_pool #(
  parameter int LAYER_HEIGHT = 13,
  parameter int WORD_SIZE    = 16,
  parameter int INT_BITS     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wen_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic                 full_o,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] data_o,
  input  logic                 yumi_i
);

  localparam int FRAC_BITS = WORD_SIZE - INT_BITS;
  localparam int SUM_W     = WORD_SIZE + $clog2(LAYER_HEIGHT);
  localparam int CNT_W     = $clog2(LAYER_HEIGHT);
  localparam int RECIP     = (2**FRAC_BITS + LAYER_HEIGHT/2) / LAYER_HEIGHT;
  // RECIP fits in FRAC_BITS bits, so SUM_W+FRAC_BITS+1 covers the product plus the rounding add.
  localparam int PROD_W    = SUM_W + FRAC_BITS + 1;

  localparam logic signed [PROD_W-1:0] RECIP_S  = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(2**(FRAC_BITS-1));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(2**(WORD_SIZE-1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = -SAT_MAX - PROD_W'(1);

  typedef enum logic [1:0] {ACCUM, CALC, DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [WORD_SIZE-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      full_q, full_d;

  logic                      accept;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  rnd;

  assign accept = wen_i & ~full_q;
  assign prod   = PROD_W'(acc_q) * RECIP_S;
  // Arithmetic shift after adding half an LSB rounds ties toward +inf.
  assign rnd    = (prod + HALF_LSB) >>> FRAC_BITS;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    data_d  = data_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + SUM_W'($signed(data_i));
          if (count_q == CNT_W'(LAYER_HEIGHT - 1)) begin
            count_d = '0;
            state_d = CALC;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      CALC: begin
        if (rnd > SAT_MAX)      data_d = SAT_MAX[WORD_SIZE-1:0];
        else if (rnd < SAT_MIN) data_d = SAT_MIN[WORD_SIZE-1:0];
        else                    data_d = rnd[WORD_SIZE-1:0];
        acc_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        if (yumi_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    full_d  = (state_d != ACCUM);
    valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign full_o  = full_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: doc/global_avg_pool.md
Name: global_avg_pool

Overview:
- Global-average-pooling stage for one convolution channel.
- Sits downstream of the per-kernel serializer and abs stage, fed over the serializer's write-enable/full interface.
- Accumulates exactly LAYER_HEIGHT signed fixed-point samples per frame and emits one rounded, saturated average word.
- The output goes to the hidden fully-connected layer over a valid/yumi handshake. One instance per kernel.

Parameters:
- LAYER_HEIGHT, 13: samples per frame, ≥2 (conv output height 16-4+1).
- WORD_SIZE, 16: data word width, signed two's complement.
- INT_BITS, 4: integer bits incl. sign; FRAC_BITS = WORD_SIZE-INT_BITS.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- wen_i  input  1  upstream write strobe; sample accepted when wen_i & ~full_o.
- data_i  input  WORD_SIZE  signed sample, Q(INT_BITS).(FRAC_BITS).
- full_o  output  1  high = not accepting samples.
- valid_o  output  1  average available on data_o.
- data_o  output  WORD_SIZE  signed average, same Q format.
- yumi_i  input  1  downstream consumes data_o this cycle; legal only when valid_o=1.

Behaviour:
- Localparams:
  - SUM_W = WORD_SIZE + $clog2(LAYER_HEIGHT).
  - RECIP = (2**FRAC_BITS + LAYER_HEIGHT/2) / LAYER_HEIGHT, an unsigned constant (315 for defaults).
- State machine: ACCUM, CALC, DONE. Reset enters ACCUM.
- Reset state: acc=0, count=0, valid_o=0, data_o=0, full_o=0. Reset has priority over all other inputs and may arrive mid-frame; the partial sum is discarded.
- ACCUM:
  - full_o=0.
  - On an accepted sample: acc += sign-extended data_i; count++.
  - When the accepted sample is number LAYER_HEIGHT (count==LAYER_HEIGHT-1), go to CALC and clear count.
  - No wen_i means hold.
- CALC (1 cycle):
  - full_o=1.
  - prod = acc * RECIP (signed × unsigned, full width).
  - rnd = (prod + 2**(FRAC_BITS-1)) >>> FRAC_BITS, i.e. arithmetic shift, round half toward +inf.
  - Saturate rnd to [-2**(WORD_SIZE-1), 2**(WORD_SIZE-1)-1].
  - Register the result into data_o, clear acc, go to DONE.
- DONE:
  - valid_o=1, full_o=1.
  - data_o is held stable until yumi_i.
  - On yumi_i, go to ACCUM; valid_o=0 and full_o=0 from the next cycle.
- Latency: last sample accepted at edge k → CALC during cycle k..k+1 → valid_o=1 after edge k+1. Best-case throughput is one average per LAYER_HEIGHT+2 cycles with yumi_i tied high.
- wen_i while full_o=1: sample ignored, no state change. The upstream must not do this; the bench flags it as a warning only.
- yumi_i while valid_o=0: ignored.
- yumi_i in the same cycle valid_o rises (DONE entry cycle): consumed; the next frame can start the following cycle.
- The accumulator never overflows for LAYER_HEIGHT full-scale samples, because SUM_W provides the headroom.
- data_o retains its last value after consumption. It is don't-care while valid_o=0 but must not be X.

Test Plan:
- Values below use defaults; 0x1000 = 1.0.
- 13 samples of 0x1000, yumi_i tied 1 → valid_o high 2 cycles after 13th accept, data_o=0x0FFF (reciprocal rounding error intentional). full_o high exactly 2 cycles.
- 13 samples of 0xF000 (-1.0) → data_o=0xF001. 13 samples of 0x0000 → data_o=0x0000.
- Raw ramp 1..13 with random wen_i gaps → data_o=0x0007. Gaps must not affect the result or count.
- 13 samples of 0x7FFF → data_o=0x7FF7, no saturation and no accumulator wrap.
- Backpressure:
  - Complete a frame, hold yumi_i=0 for 5 cycles while pulsing wen_i with 0x7000 → valid_o, data_o and full_o stay stable, and the pulsed samples are dropped.
  - Assert yumi_i → next cycle valid_o=0, full_o=0.
  - A following frame of 13×0x1000 → 0x0FFF.
- Reset mid-operation:
  - Accept 6 samples of 0x7000, assert reset_i 1 cycle → all outputs zero.
  - Then 13×0x1000 → 0x0FFF, proving no residue.
  - Repeat with reset_i asserted in CALC and in DONE.
